// File: rtl/fifo_frame_reader_if.sv
// Signal bundle for fifo_frame_reader: the FIFO read port on one side and
// the frame-tagged sample stream on the other.
interface fifo_frame_reader_if #(
    parameter int DWL = 16,
    parameter int FLW = 8,
    parameter int FCW = 16
);
    logic           FIFO_EMPTY;
    logic           FIFO_INC;
    logic [DWL-1:0] FIFO_DATA;
    logic [DWL-1:0] O_DATA;
    logic           O_VALID;
    logic           I_READY;
    logic [FLW-1:0] O_IDX;
    logic           O_FIRST;
    logic           O_LAST;
    logic [FCW-1:0] FRAME_CNT;

    // Reader side: pops the FIFO and presents the sample stream.
    modport master (
        input  FIFO_EMPTY, FIFO_DATA, I_READY,
        output FIFO_INC, O_DATA, O_VALID, O_IDX, O_FIRST, O_LAST, FRAME_CNT
    );

    // Environment side: FIFO read port and downstream consumer.
    modport slave (
        output FIFO_EMPTY, FIFO_DATA, I_READY,
        input  FIFO_INC, O_DATA, O_VALID, O_IDX, O_FIRST, O_LAST, FRAME_CNT
    );
endinterface

// File: rtl/fifo_frame_reader.sv
// Read-domain drain of the dual-clock sample FIFO. A 2-entry skid buffer
// hides the FIFO's registered read latency so the valid/ready stream runs at
// one sample per cycle, and each sample is tagged with its index inside a
// 2^FLW-point FFT frame while completed frames are counted.
module fifo_frame_reader #(
    parameter int DWL = 16,
    parameter int FLW = 8,
    parameter int FCW = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    fifo_frame_reader_if.master bus
);

    logic [1:0]     count_q,    count_d;
    logic           inflight_q, inflight_d;
    logic           valid_q,    valid_d;
    logic [DWL-1:0] buf_q [2];
    logic [DWL-1:0] buf_d [2];
    logic [FLW-1:0] idx_q,      idx_d;
    logic [FCW-1:0] frame_q,    frame_d;

    logic           pop;
    logic           fire;
    logic           first_hit;
    logic           last_hit;
    logic [2:0]     occ_after;

    // Handshakes and the issue rule: a new pop is allowed only if the entries
    // left after this cycle's output plus the word in flight fit in 2 slots.
    // The path from I_READY to FIFO_INC is deliberate so the stream never bubbles.
    always_comb begin
        pop       = valid_q && bus.I_READY;
        occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        fire      = !bus.FIFO_EMPTY && !CLR && (occ_after < 3'd2);
        first_hit = valid_q && (idx_q == '0);
        last_hit  = valid_q && (idx_q == {FLW{1'b1}});
    end

    // Next-state logic for the skid buffer, in-flight flag and frame tagging.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path leaves a
        // target unassigned and no latch can be inferred.
        count_d    = count_q;
        inflight_d = inflight_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];

        if (CLR) begin
            // Clear wins: drop buffered entries and the word in flight.
            count_d    = '0;
            inflight_d = 1'b0;
            idx_d      = '0;
            frame_d    = '0;
        end else begin
            inflight_d = fire;

            if (pop) begin
                idx_d = idx_q + FLW'(1);
                if (last_hit) begin
                    frame_d = frame_q + FCW'(1);
                end
            end

            unique case ({inflight_q, pop})
                2'b10: begin
                    // Capture only: append at the tail (slot = current count).
                    buf_d[count_q[0]] = bus.FIFO_DATA;
                    count_d           = count_q + 2'd1;
                end
                2'b01: begin
                    // Pop only: second entry moves to the head.
                    buf_d[0] = buf_q[1];
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy unchanged.
                    if (count_q == 2'd1) begin
                        buf_d[0] = bus.FIFO_DATA;
                    end else begin
                        buf_d[0] = buf_q[1];
                        buf_d[1] = bus.FIFO_DATA;
                    end
                end
                default: ;
            endcase
        end

        valid_d = (count_d != 2'd0);
    end

    // State registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            frame_q    <= '0;
            // NOTE: the two buffer words are reset because the head drives
            // O_DATA directly and must read 0 out of reset; larger storage
            // arrays would normally be left unreset.
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            count_q    <= count_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

    // Outputs; pop request and frame markers are forced low while in reset.
    assign bus.FIFO_INC  = fire && RST;
    assign bus.O_DATA    = buf_q[0];
    assign bus.O_VALID   = valid_q;
    assign bus.O_IDX     = idx_q;
    assign bus.O_FIRST   = first_hit && RST;
    assign bus.O_LAST    = last_hit && RST;
    assign bus.FRAME_CNT = frame_q;

endmodule
